// File: rtl/hatch_pkg.sv
// hatch_pkg: shared constants and loader state encoding for the hatch memory loader
package hatch_pkg;
   localparam logic [7:0] HATCH_SYNC = 8'hA5;
   localparam int HATCH_WORD_W = 48;
   localparam int HATCH_WORD_BYTES = 6;
   localparam int HATCH_DEPTH = 192;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_DATA,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } hatch_state_t;
endpackage

// File: rtl/hatch_word_asm.sv
// hatch_word_asm: packs six stream bytes into one big-endian 48-bit word
module hatch_word_asm
   import hatch_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic take,
   input  logic [7:0] data,
   output logic [HATCH_WORD_W-1:0] word,
   output logic complete
);
   logic [HATCH_WORD_W-9:0] sr;
   logic [2:0] cnt;
   assign complete = take && cnt == 3'(HATCH_WORD_BYTES - 1);
   assign word = {sr, data};
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sr <= '0;
         cnt <= '0;
      end else if (clr)
         cnt <= '0;
      else if (take) begin
         sr <= {sr[HATCH_WORD_W-17:0], data};
         cnt <= complete ? 3'd0 : cnt + 3'd1;
      end
endmodule

// File: rtl/hatch_loader.sv
// hatch_loader: framed byte-stream writer for the 48-bit hatch memory; holds the CPU until a good image lands.
// Define HATCH_LOADER_CSUM_EN to require a trailing XOR checksum byte per frame.
module hatch_loader
   import hatch_pkg::*;
#(
   parameter int DEPTH = HATCH_DEPTH,
   parameter int ADDR_W = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic [7:0] in_data,
   input  logic in_valid,
   output logic in_ready,
   output logic wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [HATCH_WORD_W-1:0] wr_data,
   output logic cpu_hold,
   output logic done,
   output logic error,
   output logic [ADDR_W:0] load_count
);
`ifdef HATCH_LOADER_CSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif
   hatch_state_t state;
   logic [7:0] len_hi, csum;
   logic [15:0] count, len;
   logic [HATCH_WORD_W-1:0] word;
   logic xfer, clr, word_done, last;
   assign xfer = in_valid && in_ready;
   assign len = {len_hi, in_data};
   assign clr = xfer && in_data == HATCH_SYNC && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
   assign last = 16'(load_count) + 16'd1 == count;
   hatch_word_asm u_asm (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .take(xfer && state == ST_DATA),
      .data(in_data),
      .word(word),
      .complete(word_done)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= ST_IDLE;
         in_ready <= 1'b0;
         len_hi <= '0;
         count <= '0;
         csum <= '0;
         wr_en <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         load_count <= '0;
         cpu_hold <= 1'b1;
         done <= 1'b0;
         error <= 1'b0;
      end else begin
         in_ready <= 1'b1;
         wr_en <= 1'b0;
         if (xfer)
            case (state)
               ST_IDLE, ST_DONE, ST_ERR:
                  if (clr) begin
                     state <= ST_LEN_HI;
                     load_count <= '0;
                     wr_addr <= '0;
                     csum <= '0;
                     done <= 1'b0;
                     error <= 1'b0;
                     cpu_hold <= 1'b1;
                  end
               ST_LEN_HI: begin
                  len_hi <= in_data;
                  csum <= csum ^ in_data;
                  state <= ST_LEN_LO;
               end
               ST_LEN_LO: begin
                  csum <= csum ^ in_data;
                  count <= len;
                  if (len > 16'(DEPTH)) begin
                     state <= ST_ERR;
                     error <= 1'b1;
                  end else if (len == 16'd0) begin
                     state <= CSUM_EN ? ST_CSUM : ST_DONE;
                     done <= !CSUM_EN;
                     cpu_hold <= CSUM_EN;
                  end else
                     state <= ST_DATA;
               end
               ST_DATA: begin
                  csum <= csum ^ in_data;
                  if (word_done) begin
                     wr_en <= 1'b1;
                     wr_addr <= load_count[ADDR_W-1:0];
                     wr_data <= word;
                     load_count <= load_count + 1'b1;
                     if (last) begin
                        state <= CSUM_EN ? ST_CSUM : ST_DONE;
                        done <= !CSUM_EN;
                        cpu_hold <= CSUM_EN;
                     end
                  end
               end
`ifdef HATCH_LOADER_CSUM_EN
               ST_CSUM: begin
                  state <= in_data == csum ? ST_DONE : ST_ERR;
                  done <= in_data == csum;
                  error <= in_data != csum;
                  cpu_hold <= in_data != csum;
               end
`endif
               default: state <= ST_IDLE;
            endcase
      end
endmodule
